// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file write port between the ALU path
//               (requester 0) and the load return path (requester 1). Each
//               requester owns a one-entry buffer; a round-robin arbiter with
//               same-address ordering drains them into registered write
//               outputs and tracks in-flight destinations in a bitmap.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                write_enable,
    output logic [ADDR_W-1:0]   write_addr,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                prio
);

    // Holding buffers. The age bit marks an entry that arrived while the
    // other buffer already held an older entry that was not leaving.
    logic              r_v0, r_v1;
    logic              r_age0, r_age1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic [DATA_W-1:0] r_data0, r_data1;

    logic              w_gnt0, w_gnt1, w_gnt_any;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_acc0, w_acc1;
    logic              w_v0_nxt, w_v1_nxt;
    logic [ADDR_W-1:0] w_a0_nxt, w_a1_nxt;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // Grant selection: single occupant wins, same address goes oldest-first
    // (requester 0 on a same-edge tie), otherwise the round-robin pointer.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_v0 && r_v1) begin
            if (r_addr0 == r_addr1) begin
                if (r_age0 && !r_age1) w_gnt1 = 1'b1;
                else                   w_gnt0 = 1'b1;
            end else if (prio) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else if (r_v0) begin
            w_gnt0 = 1'b1;
        end else if (r_v1) begin
            w_gnt1 = 1'b1;
        end
    end

    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign w_gnt_addr = w_gnt1 ? r_addr1 : r_addr0;
    assign w_gnt_data = w_gnt1 ? r_data1 : r_data0;

    // A buffer accepts when empty or when it is draining this cycle.
    assign req0_ready = ~r_v0 | w_gnt0;
    assign req1_ready = ~r_v1 | w_gnt1;

    // Address 0 is handshaken but never stored.
    assign w_acc0 = req0_valid & req0_ready & (req0_addr != '0);
    assign w_acc1 = req1_valid & req1_ready & (req1_addr != '0);

    assign w_v0_nxt = w_acc0 | (r_v0 & ~w_gnt0);
    assign w_v1_nxt = w_acc1 | (r_v1 & ~w_gnt1);
    assign w_a0_nxt = w_acc0 ? req0_addr : r_addr0;
    assign w_a1_nxt = w_acc1 ? req1_addr : r_addr1;

    // Next pending map: every destination that will sit in a buffer or on
    // the output registers after this edge.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pend_nxt[i] = (w_v0_nxt  && (w_a0_nxt   == ADDR_W'(i))) ||
                            (w_v1_nxt  && (w_a1_nxt   == ADDR_W'(i))) ||
                            (w_gnt_any && (w_gnt_addr == ADDR_W'(i)));
        end
    end

    // Buffer 0 fill/drain and age tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0    <= 1'b0;
            r_age0  <= 1'b0;
            r_addr0 <= '0;
            r_data0 <= '0;
        end else begin
            r_v0 <= w_v0_nxt;
            if (w_acc0) begin
                r_addr0 <= req0_addr;
                r_data0 <= req0_data;
                r_age0  <= r_v1 & ~w_gnt1;
            end else if (w_gnt1) begin
                r_age0  <= 1'b0;
            end
        end
    end

    // Buffer 1 fill/drain and age tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_age1  <= 1'b0;
            r_addr1 <= '0;
            r_data1 <= '0;
        end else begin
            r_v1 <= w_v1_nxt;
            if (w_acc1) begin
                r_addr1 <= req1_addr;
                r_data1 <= req1_data;
                r_age1  <= r_v0 & ~w_gnt0;
            end else if (w_gnt0) begin
                r_age1  <= 1'b0;
            end
        end
    end

    // Output write port registers, round-robin pointer and pending map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            prio         <= 1'b0;
            pending      <= '0;
        end else begin
            write_enable <= w_gnt_any;
            if (w_gnt_any) begin
                write_addr <= w_gnt_addr;
                write_data <= w_gnt_data;
            end
            if (w_gnt0)      prio <= 1'b1;
            else if (w_gnt1) prio <= 1'b0;
            pending <= w_pend_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU/immediate path and requester 1 is the load/memory return path. Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter with same-address ordering protection drains the buffers into registered `write_enable`/`write_addr`/`write_data` outputs that connect directly to the register file. The block also publishes a pending-write bitmap that the hazard logic uses to stall reads of registers whose writes are still in flight.

## Interface
- `NUM_REGS`, 32: register count; the `pending` width.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: write data width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 offers a write.
- `req0_ready`  out  1  requester 0 buffer can accept this cycle.
- `req0_addr`  in  ADDR_W  requester 0 destination register.
- `req0_data`  in  DATA_W  requester 0 write data.
- `req1_valid` / `req1_ready` / `req1_addr` / `req1_data`: same as requester 0, for requester 1.
- `write_enable`  out  1  registered write strobe to the register file.
- `write_addr`  out  ADDR_W  registered write address.
- `write_data`  out  DATA_W  registered write data.
- `pending`  out  NUM_REGS  bit i is 1 while a write to register i is buffered or on the output registers.
- `prio`  out  1  round-robin pointer; the requester favoured on the next tie.

## Operation
- Acceptance occurs at the rising edge where `reqN_valid & reqN_ready` is 1.
- `reqN_ready` is 1 when buffer N is empty, or when buffer N is granted in the current cycle (drain-and-refill in the same cycle is allowed).
- A request with address 0 is accepted and discarded. The buffer stays empty, no write is issued, and no `pending` bit is set.
- Each buffer stores addr, data, and an age bit. The age bit is 1 if the entry was accepted while the other buffer already held an entry.
- Grant is combinational and one grant is issued per cycle:
  - Only one buffer full: that buffer is granted.
  - Both full, same address: the older entry (age bit clear) is granted. If both were accepted on the same edge, requester 0 is granted.
  - Both full, different addresses: `prio` selects the granted buffer.
- After any grant, `prio` moves to the non-granted requester. With no grant, `prio` holds.
- On the edge after a grant:
  - the output registers load the granted addr/data;
  - `write_enable` is 1 for exactly one cycle;
  - the granted buffer empties, unless it is refilled on the same edge.
- `pending`:
  - bit set on the acceptance edge;
  - bit cleared on the edge that ends the `write_enable` cycle, unless another in-flight entry (in either buffer or being accepted) targets the same register.

## Timing
- Reset values:
  - `write_enable`=0, `write_addr`=0, `write_data`=0;
  - `pending`=0, `prio`=0 (requester 0 favoured);
  - both buffers empty, so `req0_ready`=`req1_ready`=1 during and after reset.
- Latency from the acceptance edge E to `write_enable` high: 1 cycle when uncontended (high in the cycle after E+1). Each cycle lost to arbitration adds 1 cycle.
- Sustained throughput is one register file write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1 (different addresses).
- Buffer full and not granted: `reqN_ready`=0 and the requester must hold `valid`/`addr`/`data` stable.
- `rst` asserted mid-operation:
  - buffers flush immediately and in-flight writes are lost;
  - `write_enable` drops asynchronously;
  - `pending` clears to 0.
- Output registers drive the register file directly; there is no combinational path from `reqN_*` to `write_*`.

## Test plan
- Reset, then `req0` writes addr 5 with 0xDEADBEEF → `req0_ready`=1; `pending[5]`=1 from E; `write_enable`=1 for one cycle after E+1 with addr 5 and data 0xDEADBEEF; then `pending[5]`=0.
- Both requesters valid every cycle, addrs 3/7, `prio`=0 → write order 3,7,3,7; each `req_ready` toggles; one write per cycle; no data lost.
- `req1` accepts addr 9 data 0x1 at edge E; `req0` accepts addr 9 data 0x2 at E+1 while `prio`=0 → addr 9 written with 0x1 first, then 0x2; `pending[9]` stays 1 until the second write completes.
- `req0` and `req1` valid with addr 0 → both accepted; `write_enable` stays 0; `pending`=0.
- Both buffers full (addrs 4 and 12), `rst` pulsed mid-cycle → `write_enable` drops without waiting for a clock edge; `pending`=0; both readies 1; no write to 4 or 12 occurs after reset release.
- Buffer 0 full and granted while `req0_valid` is held with a new request → the new entry is accepted on the same edge (`req0_ready`=1) with no bubble, and two consecutive writes appear.
